mem_port_arbiter: RTL
=====================

// Module: mem_port_arbiter
// PURPOSE
//  Shares the single unified memory port between instruction fetch (IF) and the
//  MEM stage. One transaction is outstanding at a time. MEM has priority, with a
//  starvation guard for fetch. A taken branch squashes an in-flight fetch.
//  Drives the IF/MEM stall signals consumed by the pipeline.
// PARAMETERS
//  ADDR_W        32  address width of all request ports
//  DATA_W        32  data width of all read/write data ports
//  STARVE_LIMIT  4   consecutive MEM grants allowed while IF waits; then IF wins (>=1)
// PORTS
//  clk            in   1       system clock, rising edge
//  rst            in   1       asynchronous reset, active-low
//  if_req_valid   in   1       fetch request; held with addr until if_resp_valid
//  if_req_addr    in   ADDR_W  fetch address, word aligned
//  if_flush       in   1       taken-branch squash of current fetch
//  if_resp_valid  out  1       fetch data valid this cycle
//  if_resp_data   out  DATA_W  fetched instruction
//  if_stall       out  1       if_req_valid & ~if_resp_valid
//  mem_req_valid  in   1       load/store request; held until mem_resp_valid
//  mem_req_write  in   1       1 = store, 0 = load
//  mem_req_addr   in   ADDR_W  load/store address
//  mem_req_wdata  in   DATA_W  store data
//  mem_resp_valid out  1       load data / store ack valid this cycle
//  mem_resp_rdata out  DATA_W  load data (undefined for store ack)
//  mem_stall      out  1       mem_req_valid & ~mem_resp_valid
//  mport_req_valid out 1       request to memory
//  mport_req_ready in  1       memory accepts request when valid&ready
//  mport_req_write out 1       request is a store
//  mport_req_addr out  ADDR_W  request address
//  mport_req_wdata out DATA_W  store data
//  mport_resp_valid in 1       response (read data or write ack), any latency >=1
//  mport_resp_data in  DATA_W  read data
// BEHAVIOUR
//  - Reset (rst=0, async): state=IDLE, starve_cnt=0. With requests low, all outputs are 0.
//  - FSM states: IDLE, WAIT_IF, WAIT_MEM, DRAIN.
//  - IDLE grant rule:
//     - grant IF if if_req_valid & ~if_flush & (~mem_req_valid | starve_cnt==STARVE_LIMIT);
//     - else grant MEM if mem_req_valid.
//  - IDLE drive: mport_req_valid=1 with the granted fields, combinationally (same cycle).
//  - IDLE issue: on the mport_req_ready edge, go to WAIT_IF or WAIT_MEM. No ready: stay, re-arbitrate next cycle.
//  - WAIT_x: mport_req_valid=0, no new issue. mport_resp_valid passes through in the same cycle:
//     - owner resp_valid=1 (zero latency), data=mport_resp_data;
//     - next state IDLE, so a new issue is possible on the following cycle.
//  - Flush:
//     - if_flush in WAIT_IF without mport_resp_valid: go to DRAIN.
//     - if_flush with mport_resp_valid: if_resp_valid=0, go to IDLE.
//     - DRAIN: on mport_resp_valid, discard the response, go to IDLE. No issue until then.
//     - if_flush in WAIT_MEM or DRAIN: no effect.
//  - starve_cnt:
//     - +1 per MEM issue while if_req_valid=1, saturating at STARVE_LIMIT;
//     - cleared on IF issue, or when if_req_valid=0 in IDLE.
//  - mport_resp_valid in IDLE (spurious, e.g. after a mid-op reset): ignored, no response pulse.
//  - Reset mid-transaction: the outstanding transaction is abandoned and no response is forwarded.
//  - Single outstanding: never two mport requests without an intervening response.
// TESTING
//  - IF only, resp latency 3: addr 0x0,0x4,0x8 -> each if_resp_valid 1 cycle; if_stall=1 for 3 cycles per fetch.
//  - IF+MEM both valid in IDLE, STARVE_LIMIT=4, MEM reissues continuously:
//     4 MEM grants, 5th grant to IF, then starve_cnt=0.
//  - Flush in WAIT_IF at addr 0x10, resp 2 cycles later:
//     DRAIN entered; resp discarded; next issue uses the new addr 0x40.
//  - Flush coincident with mport_resp_valid: if_resp_valid=0, state IDLE next cycle.
//  - Store 0xDEADBEEF@0x100 then load @0x100, ready low 2 cycles:
//     write issued once; mem_resp_valid ack; load returns 0xDEADBEEF.
//  - Async reset asserted in WAIT_MEM, spurious resp after release:
//     outputs 0, no mem_resp_valid pulse, next request issues normally.

Source files
------------

// File: rtl/mem_port_arbiter_if.sv
// Bundle of the fetch, load/store and unified memory-port handshakes around mem_port_arbiter.
// The slave modport is the arbiter's view; the master modport is the pipeline plus memory side.
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              if_req_valid;
    logic [ADDR_W-1:0] if_req_addr;
    logic              if_flush;
    logic              if_resp_valid;
    logic [DATA_W-1:0] if_resp_data;
    logic              if_stall;

    logic              mem_req_valid;
    logic              mem_req_write;
    logic [ADDR_W-1:0] mem_req_addr;
    logic [DATA_W-1:0] mem_req_wdata;
    logic              mem_resp_valid;
    logic [DATA_W-1:0] mem_resp_rdata;
    logic              mem_stall;

    logic              mport_req_valid;
    logic              mport_req_ready;
    logic              mport_req_write;
    logic [ADDR_W-1:0] mport_req_addr;
    logic [DATA_W-1:0] mport_req_wdata;
    logic              mport_resp_valid;
    logic [DATA_W-1:0] mport_resp_data;

    modport slave (
        input  if_req_valid, if_req_addr, if_flush,
        output if_resp_valid, if_resp_data, if_stall,
        input  mem_req_valid, mem_req_write, mem_req_addr, mem_req_wdata,
        output mem_resp_valid, mem_resp_rdata, mem_stall,
        output mport_req_valid, mport_req_write, mport_req_addr, mport_req_wdata,
        input  mport_req_ready, mport_resp_valid, mport_resp_data
    );

    modport master (
        output if_req_valid, if_req_addr, if_flush,
        input  if_resp_valid, if_resp_data, if_stall,
        output mem_req_valid, mem_req_write, mem_req_addr, mem_req_wdata,
        input  mem_resp_valid, mem_resp_rdata, mem_stall,
        input  mport_req_valid, mport_req_write, mport_req_addr, mport_req_wdata,
        output mport_req_ready, mport_resp_valid, mport_resp_data
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between fetch and MEM stage, one transaction outstanding at a time.
// MEM has priority; fetch wins after STARVE_LIMIT consecutive MEM issues while it waits.
//
//   state    | meaning
//   IDLE     | arbitrate and drive the granted request to the port
//   WAIT_IF  | fetch outstanding, response forwarded in the cycle it arrives
//   WAIT_MEM | load/store outstanding, response forwarded in the cycle it arrives
//   DRAIN    | squashed fetch outstanding, response will be dropped
module mem_port_arbiter #(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int STARVE_LIMIT = 4
) (
    input logic               clk,
    input logic               rst,
    mem_port_arbiter_if.slave bus
);
    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_IF  = 2'd1,
        WAIT_MEM = 2'd2,
        DRAIN    = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  starve_cnt_q, starve_cnt_d;

    logic              grant_if;
    logic              grant_mem;
    logic              mport_req_valid_c;
    logic              mport_req_write_c;
    logic [ADDR_W-1:0] mport_req_addr_c;
    logic [DATA_W-1:0] mport_req_wdata_c;
    logic              if_resp_valid_c;
    logic [DATA_W-1:0] if_resp_data_c;
    logic              mem_resp_valid_c;
    logic [DATA_W-1:0] mem_resp_rdata_c;

    // A flushing fetch is never granted, so the squashed address cannot reach memory.
    assign grant_if  = bus.if_req_valid & ~bus.if_flush &
                       (~bus.mem_req_valid | (starve_cnt_q == CNT_MAX));
    assign grant_mem = ~grant_if & bus.mem_req_valid;

    always_comb begin
        state_d           = state_q;
        starve_cnt_d      = starve_cnt_q;
        mport_req_valid_c = 1'b0;
        mport_req_write_c = 1'b0;
        mport_req_addr_c  = '0;
        mport_req_wdata_c = '0;
        if_resp_valid_c   = 1'b0;
        if_resp_data_c    = '0;
        mem_resp_valid_c  = 1'b0;
        mem_resp_rdata_c  = '0;

        case (state_q)
            IDLE: begin
                if (!bus.if_req_valid) begin
                    starve_cnt_d = '0;
                end
                if (grant_if) begin
                    mport_req_valid_c = 1'b1;
                    mport_req_addr_c  = bus.if_req_addr;
                    if (bus.mport_req_ready) begin
                        state_d      = WAIT_IF;
                        starve_cnt_d = '0;
                    end
                end else if (grant_mem) begin
                    mport_req_valid_c = 1'b1;
                    mport_req_write_c = bus.mem_req_write;
                    mport_req_addr_c  = bus.mem_req_addr;
                    mport_req_wdata_c = bus.mem_req_wdata;
                    if (bus.mport_req_ready) begin
                        state_d = WAIT_MEM;
                        if (bus.if_req_valid && (starve_cnt_q != CNT_MAX)) begin
                            starve_cnt_d = starve_cnt_q + CNT_W'(1);
                        end
                    end
                end
            end
            WAIT_IF: begin
                if (bus.mport_resp_valid) begin
                    if_resp_valid_c = ~bus.if_flush;
                    if_resp_data_c  = bus.if_flush ? '0 : bus.mport_resp_data;
                    state_d         = IDLE;
                end else if (bus.if_flush) begin
                    state_d = DRAIN;
                end
            end
            WAIT_MEM: begin
                if (bus.mport_resp_valid) begin
                    mem_resp_valid_c = 1'b1;
                    mem_resp_rdata_c = bus.mport_resp_data;
                    state_d          = IDLE;
                end
            end
            DRAIN: begin
                if (bus.mport_resp_valid) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            starve_cnt_q <= '0;
        end else begin
            state_q      <= state_d;
            starve_cnt_q <= starve_cnt_d;
        end
    end

    assign bus.mport_req_valid = mport_req_valid_c;
    assign bus.mport_req_write = mport_req_write_c;
    assign bus.mport_req_addr  = mport_req_addr_c;
    assign bus.mport_req_wdata = mport_req_wdata_c;
    assign bus.if_resp_valid   = if_resp_valid_c;
    assign bus.if_resp_data    = if_resp_data_c;
    assign bus.mem_resp_valid  = mem_resp_valid_c;
    assign bus.mem_resp_rdata  = mem_resp_rdata_c;
    assign bus.if_stall        = bus.if_req_valid & ~if_resp_valid_c;
    assign bus.mem_stall       = bus.mem_req_valid & ~mem_resp_valid_c;
endmodule
